// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; result is {HI, LO} for the requested op.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] sa_s;
  logic signed [63:0] sb_s;
  logic        [31:0] divisor_s;
  logic signed [31:0] sq_s;
  logic signed [31:0] sr_s;
  logic        [31:0] uq_s;
  logic        [31:0] ur_s;

  // Divide by a safe divisor so a zero divisor never reaches the dividers; the flag suppresses commit.
  always_comb begin
    sa_s      = {{32{src_a[31]}}, src_a};
    sb_s      = {{32{src_b[31]}}, src_b};
    div_zero  = is_div_op(md_op) && (src_b == 32'd0);
    divisor_s = (src_b == 32'd0) ? 32'd1 : src_b;
    if ((src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF)) begin
      sq_s = 32'sh8000_0000;
      sr_s = 32'sd0;
    end else begin
      sq_s = $signed(src_a) / $signed(divisor_s);
      sr_s = $signed(src_a) % $signed(divisor_s);
    end
    uq_s = src_a / divisor_s;
    ur_s = src_a % divisor_s;
    case (md_op)
      MD_MULT:  result = sa_s * sb_s;
      MD_MULTU: result = {32'd0, src_a} * {32'd0, src_b};
      MD_DIV:   result = {sr_s, sq_s};
      MD_DIVU:  result = {ur_s, uq_s};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div controller: holds a precomputed result for a fixed latency,
// then commits it to the architectural HI/LO registers.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        hilo_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      arith_res_s;
  logic             div_zero_s;
  logic             accept_s;

  mdu_arith u_arith (
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .result   (arith_res_s),
    .div_zero (div_zero_s)
  );

  assign busy     = (state_q == RUN);
  assign accept_s = start & ~flush & ~busy & (md_op <= 3'd5);
  assign stall    = hilo_use & (busy | accept_s);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Next-state: accept in IDLE, count down in RUN and commit on the final cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (md_op)
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: begin
              state_d  = RUN;
              res_hi_d = arith_res_s[63:32];
              res_lo_d = arith_res_s[31:0];
              dz_d     = div_zero_s;
              cnt_d    = is_div_op(md_op) ? CNT_DIV : CNT_MULT;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          // A zero divisor runs the full latency but leaves HI/LO untouched.
          if (!dz_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and architectural registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller alongside the EX-stage ALU. Accepts mult/multu/div/divu and mthi/mtlo from EX, holds operand-derived results for a fixed latency while asserting `busy`, then commits them to the architectural HI/LO registers. Drives the pipeline stall for any HI/LO access during an in-flight operation. Honours the exception `flush` so a faulting instruction never starts an operation.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (must be ≥1).
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX holds an MDU instruction this cycle.
- `md_op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved.
- `src_a`  in  32  rs value (dividend / multiplicand / mthi-mtlo data).
- `src_b`  in  32  rt value (divisor / multiplier).
- `flush`  in  1  exception/interrupt flush of EX this cycle.
- `hilo_use`  in  1  EX instruction reads/writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- `busy`  out  1  operation in flight.
- `stall`  out  1  combinational: `hilo_use & (busy | accept)`; `accept` is defined below.
- `hi`, `lo`  out  32 each  architectural HI/LO.

## Operation
- States: IDLE, RUN. Down-counter `cnt` (width covering max latency), pending result regs `res_hi`, `res_lo`.
- `accept = start & ~flush & ~busy & md_op ≤ 5`.
- IDLE, `accept` with op 0–3: latch 64-bit result into `res_hi`/`res_lo`, load `cnt` with MULT_CYCLES or DIV_CYCLES, go to RUN.
- IDLE, `accept` with op 4/5: write `src_a` to `hi`/`lo` at that edge; remain IDLE; no busy.
- RUN: decrement `cnt`; on edge where `cnt == 1`, write `hi <= res_hi`, `lo <= res_lo`, go to IDLE.
- `start` while busy: ignored (pipeline is stalled; no state change). Reserved op: ignored.
- `flush` blocks acceptance in the same cycle only; an operation already in RUN always completes and commits.
- Arithmetic:
  - mult: signed 64-bit product, HI = [63:32], LO = [31:0]; multu: unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with sign of dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor 0 (div/divu): full DIV_CYCLES busy; HI/LO retain prior values at commit.
- Reset (async, any time including mid-RUN): state IDLE, `cnt` = 0, `busy` = 0, `hi` = `lo` = 0, `res_*` = 0; the in-flight op is discarded.

## Timing
- Edge E0 samples `accept`. `busy` = 1 in the N cycles following E0; HI/LO are updated at edge E0+N, and `busy` falls at the same edge.
- `busy` is a registered output (state == RUN); `stall` is combinational.
- mfhi/mflo in EX at cycle E0+N reads the new value; in any earlier cycle it is stalled.
- mthi/mtlo result is visible the cycle after its edge.
- Back-to-back: a new op can be accepted at edge E0+N.

## Structure
- Package `mdu_pkg`: `md_op` encodings (MD_MULT … MD_MTLO), default latencies, state enum {IDLE, RUN}.
- Sub-module `mdu_arith`: purely combinational; inputs `md_op`, `src_a`, `src_b`; outputs a 64-bit result and a `div_zero` flag. This isolates the signed/unsigned corner cases. The controller instantiates it once.

## Test plan
- Reset, then mult 0xFFFFFFFF × 0x00000002: `busy` is high for exactly 5 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFE at edge E0+5. With multu on the same operands: HI = 0x00000001, LO = 0xFFFFFFFE.
- div −7 / 2: after 10 cycles, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. div 0x80000000 / −1: LO = 0x80000000, HI = 0.
- mthi 0x1234 then divu 5 / 0: HI stays 0x1234 and LO stays at its prior value after 10 busy cycles.
- `start` and `flush` asserted together with mult: no busy, HI/LO unchanged. `flush` asserted during RUN: the result still commits.
- mult in flight with `hilo_use` = 1 (mflo) on each cycle: `stall` = 1 through E0+4 and drops at E0+5 with the new LO. A second `start` during busy is ignored.
- Assert `rst_n` low at E0+3 of a div: `busy`, `hi`, `lo` are immediately 0. After release, a fresh mult completes normally.
